// File: rtl/sc_pkg.sv
// Shared types and sizing helpers for the stochastic-to-binary converter.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } sc_conv_state_t;

    localparam int SC_DEFAULT_WINDOW_BITS = 8;

    // Number of samples in one conversion window.
    function automatic int sc_window_len(input int window_bits);
        return 1 << window_bits;
    endfunction

    // Two extra bits hold the full count N and, in the bipolar build, the sign.
    function automatic int sc_result_width(input int window_bits);
        return window_bits + 2;
    endfunction

endpackage

// File: rtl/sc_stream_to_binary_if.sv
// Handshake bundle between the stochastic-to-binary converter and its consumer.
interface sc_stream_to_binary_if #(
    parameter int WINDOW_BITS = 8
);
    logic                   start;
    logic                   bit_in;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [WINDOW_BITS+1:0] result;

    modport master (
        output start,
        output bit_in,
        output out_ready,
        input  busy,
        input  out_valid,
        input  result
    );

    modport slave (
        input  start,
        input  bit_in,
        input  out_ready,
        output busy,
        output out_valid,
        output result
    );
endinterface

// File: rtl/sc_window_counter.sv
// Sample counter plus ones accumulator for one fixed-length stochastic window.
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int WINDOW_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 bit_in,
    output logic [WINDOW_BITS:0] ones,
    output logic                 last_sample
);
    localparam int N = sc_window_len(WINDOW_BITS);

    logic [WINDOW_BITS-1:0] sample_cnt;

    // Clear wins over enable; the sample counter wraps naturally after N samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt <= '0;
            ones       <= '0;
        end else if (clear) begin
            sample_cnt <= '0;
            ones       <= '0;
        end else if (enable) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones       <= ones + (WINDOW_BITS+1)'(bit_in);
        end
    end

    assign last_sample = (sample_cnt == WINDOW_BITS'(N - 1));

endmodule

// File: rtl/sc_stream_to_binary.sv
// Counts ones of a stochastic bitstream over 2^WINDOW_BITS cycles and hands the
// count out with valid/ready. Define SC_BIPOLAR_EN for a signed 2*ones-N result.
module sc_stream_to_binary
    import sc_pkg::*;
#(
    parameter int WINDOW_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sc_stream_to_binary_if.slave   bus
);
    localparam int N  = sc_window_len(WINDOW_BITS);
    localparam int RW = sc_result_width(WINDOW_BITS);

    sc_conv_state_t         state_q;
    sc_conv_state_t         state_d;
    logic                   cnt_clear;
    logic                   cnt_enable;
    logic                   load_result;
    logic                   last_sample;
    logic [WINDOW_BITS:0]   ones;
    logic [WINDOW_BITS:0]   final_count;
    logic [RW-1:0]          result_d;
    logic [RW-1:0]          result_q;

    sc_window_counter #(
        .WINDOW_BITS (WINDOW_BITS)
    ) u_window_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (cnt_clear),
        .enable      (cnt_enable),
        .bit_in      (bus.bit_in),
        .ones        (ones),
        .last_sample (last_sample)
    );

    // The last sample is still in flight on the capture edge, so fold it in here.
    assign final_count = ones + (WINDOW_BITS+1)'(bus.bit_in);

`ifdef SC_BIPOLAR_EN
    assign result_d = {final_count, 1'b0} - RW'(N);
`else
    assign result_d = {1'b0, final_count};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_result) begin
                result_q <= result_d;
            end
        end
    end

    // A HOLD handshake with start asserted restarts directly, skipping IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        load_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_clear = 1'b1;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                cnt_enable = 1'b1;
                if (last_sample) begin
                    load_result = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (bus.start) begin
                        cnt_clear = 1'b1;
                        state_d   = ACCUM;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_sc_stream_to_binary.sv
// Self-checking bench for sc_stream_to_binary with an 8-sample window; honours SC_BIPOLAR_EN.
module tb_sc_stream_to_binary;
    import sc_pkg::*;

    localparam int WB = 3;
    localparam int N  = sc_window_len(WB);
    localparam int RW = sc_result_width(WB);

    typedef struct {
        logic [N-1:0] pat;
        int           exp_ones;
        int           hold;
        bit           b2b;
        bit           poke;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_valid_cyc = 0;
    int   expect_period  = 0;
    logic [RW-1:0] exp_q = '0;
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sc_stream_to_binary_if #(.WINDOW_BITS(WB)) bus();

    sc_stream_to_binary #(.WINDOW_BITS(WB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: result is just the ones count, or 2*ones-N in the bipolar build.
    function automatic logic [RW-1:0] expected_from_ones(input int ones);
`ifdef SC_BIPOLAR_EN
        return RW'(2 * ones - N);
`else
        return RW'(ones);
`endif
    endfunction

    function automatic logic [RW-1:0] model_result(input logic [N-1:0] samples);
        int ones = 0;
        for (int i = 0; i < N; i++) ones += 32'(samples[i]);
        return expected_from_ones(ones);
    endfunction

    task automatic start_from_idle();
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Feeds one window; assumes the converter has just entered ACCUM.
    task automatic apply_stimulus(input logic [N-1:0] pat, input bit poke, input logic [RW-1:0] exp, input string tag);
        for (int i = 0; i < N; i++) begin
            check_output($sformatf("%s busy s%0d", tag, i), 32'(bus.busy), 32'd1);
            check_output($sformatf("%s early_valid s%0d", tag, i), 32'(bus.out_valid), 32'd0);
            bus.bit_in = pat[i];
            bus.start  = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        bus.start  = 1'b0;
        bus.bit_in = 1'($urandom);
        check_output({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check_output({tag, " busy_done"}, 32'(bus.busy), 32'd0);
        check_output({tag, " result"}, 32'(bus.result), 32'(exp));
        if (expect_period > 0)
            check_output({tag, " period"}, 32'(cyc - last_valid_cyc), 32'(expect_period));
        last_valid_cyc = cyc;
        expect_period  = 0;
        exp_q          = exp;
    endtask

    task automatic release_result(input int hold, input bit next_start, input bit poke, input string tag);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.start     = poke;
            @(negedge clk);
            check_output($sformatf("%s hold_valid h%0d", tag, h), 32'(bus.out_valid), 32'd1);
            check_output($sformatf("%s hold_result h%0d", tag, h), 32'(bus.result), 32'(exp_q));
        end
        bus.out_ready = 1'b1;
        bus.start     = next_start;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check_output({tag, " valid_dropped"}, 32'(bus.out_valid), 32'd0);
        check_output({tag, " next_busy"}, 32'(bus.busy), 32'(next_start));
        if (next_start) expect_period = N + 1 + hold;
    endtask

    initial begin
        bit in_accum;
        bit nb;
        logic [N-1:0] pat;

        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.bit_in    = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        check_output("reset busy", 32'(bus.busy), 32'd0);
        check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset result", 32'(bus.result), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        bus.out_ready = 1'b1;
        bus.bit_in    = 1'b1;
        repeat (2) @(negedge clk);
        check_output("idle ready valid", 32'(bus.out_valid), 32'd0);
        check_output("idle ready busy", 32'(bus.busy), 32'd0);
        bus.out_ready = 1'b0;

        vecs[0] = '{pat: 8'hFF, exp_ones: 8, hold: 0, b2b: 1'b0, poke: 1'b0};
        vecs[1] = '{pat: 8'hC5, exp_ones: 4, hold: 5, b2b: 1'b0, poke: 1'b0};
        vecs[2] = '{pat: 8'h00, exp_ones: 0, hold: 0, b2b: 1'b1, poke: 1'b0};
        vecs[3] = '{pat: 8'h5A, exp_ones: 4, hold: 0, b2b: 1'b1, poke: 1'b1};
        vecs[4] = '{pat: 8'h01, exp_ones: 1, hold: 3, b2b: 1'b0, poke: 1'b1};
        vecs[5] = '{pat: 8'h7F, exp_ones: 7, hold: 1, b2b: 1'b0, poke: 1'b0};

        in_accum = 1'b0;
        for (int v = 0; v < 6; v++) begin
            if (!in_accum) start_from_idle();
            apply_stimulus(vecs[v].pat, vecs[v].poke, expected_from_ones(vecs[v].exp_ones), $sformatf("vec%0d", v));
            nb = vecs[v].b2b && (v < 5);
            release_result(vecs[v].hold, nb, vecs[v].poke, $sformatf("vec%0d", v));
            in_accum = nb;
        end

        in_accum = 1'b0;
        for (int r = 0; r < 16; r++) begin
            pat = N'($urandom);
            if (!in_accum) start_from_idle();
            apply_stimulus(pat, 1'($urandom), model_result(pat), $sformatf("rnd%0d", r));
            nb = (r < 15) ? 1'($urandom) : 1'b0;
            release_result($urandom_range(0, 3), nb, 1'($urandom), $sformatf("rnd%0d", r));
            in_accum = nb;
        end

        start_from_idle();
        apply_stimulus(8'hFF, 1'b0, expected_from_ones(8), "pre_reset");
        release_result(0, 1'b1, 1'b0, "pre_reset");
        for (int i = 0; i < 4; i++) begin
            bus.bit_in = 1'b1;
            @(negedge clk);
        end
        check_output("mid busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("async busy", 32'(bus.busy), 32'd0);
        check_output("async out_valid", 32'(bus.out_valid), 32'd0);
        check_output("async result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expect_period = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check_output($sformatf("post_reset quiet %0d", i), 32'(bus.out_valid), 32'd0);
        end
        start_from_idle();
        apply_stimulus(8'hFF, 1'b0, expected_from_ones(8), "fresh");
        release_result(0, 1'b0, 1'b0, "fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_stream_to_binary.md
Name: sc_stream_to_binary

Overview:
- Downstream converter for the stochastic dot-product output: samples one stochastic bitstream over a fixed window of 2^WINDOW_BITS clock cycles and counts its ones.
- Presents the count as a binary result, with a valid/ready handshake to the consuming binary logic.
- Returns the datapath from the stochastic domain to the binary domain.
- Runs back-to-back conversions when the consumer keeps up.

Parameters:
- WINDOW_BITS, default 8: log2 of the window length N = 2^WINDOW_BITS samples; legal range 2..16.

Ports:
- clk  input  1  sole clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request a conversion; honoured in IDLE, or in HOLD on the cycle the result is accepted.
- bit_in  input  1  stochastic bitstream, e.g. the dot-product result.
- busy  output  1  high while in ACCUM.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result when high with out_valid.
- result  output  WINDOW_BITS+2  conversion result; format set by the optional feature.

Behaviour:
- Reset: when rst is low, asynchronously force state=IDLE, busy=0, out_valid=0, result=0, and clear the ones counter and sample counter.
- Counter widths: sample counter WINDOW_BITS wide; ones counter WINDOW_BITS+1 wide, so an all-ones window gives N without overflow. No saturation logic; the counter cannot exceed N.
- IDLE:
  - start=1 -> ACCUM; clear both counters.
  - start=0 -> remain in IDLE.
  - bit_in is ignored.
- ACCUM:
  - Every cycle: sample bit_in, ones += bit_in, sample counter += 1.
  - The cycle the sample counter is N-1 (its last sample, included in the count) -> HOLD.
  - On that transition, register result from the final count and set out_valid=1.
  - start is ignored in this state.
- Latency: start sampled high at edge k; samples taken at edges k+1..k+N; out_valid high after edge k+N.
- HOLD:
  - result and out_valid stay stable until out_valid & out_ready.
  - On handshake with start=0: -> IDLE, out_valid=0.
  - On handshake with start=1: -> ACCUM directly, counters cleared, out_valid=0.
  - Back-to-back period is therefore N+1 cycles.
  - start without out_ready is ignored.
- result is a registered output: it changes only on entry to HOLD, and on reset.
- Reset mid-ACCUM: partial count discarded; no out_valid pulse is produced.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: SC_BIPOLAR_EN.
- Defined: result is two's-complement bipolar value 2*ones - N, range -N..+N, WINDOW_BITS+2 bits signed.
- Undefined: result is unipolar, ones zero-extended to WINDOW_BITS+2 bits, range 0..N.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package sc_pkg holds:
  - state typedef sc_conv_state_t: IDLE, ACCUM, HOLD;
  - localparam function/constants for window length N and result width (WINDOW_BITS+2).
- One natural sub-module: sc_window_counter. It holds the sample counter plus ones accumulator, with clear, enable and last-sample flag.

Test Plan (WINDOW_BITS=3, N=8):
- Reset, then start pulse, bit_in all ones for 8 cycles -> out_valid after edge k+8, result=8 (bipolar build: +8).
- Start, bit_in pattern 1,0,1,0,0,0,1,1 -> result=4 (bipolar: 0); out_valid held with out_ready=0 for 5 cycles, result stable.
- Start, bit_in all zeros -> result=0 (bipolar: -8, i.e. 5'b11000).
- Back-to-back: out_ready=1 and start=1 in the same HOLD cycle -> next out_valid exactly 9 cycles later; no IDLE cycle.
- start pulsed during ACCUM and while HOLD without out_ready -> ignored; window stays 8 samples, count unchanged.
- rst low after 4 samples -> busy=0, out_valid=0, result=0 immediately (async); a new start yields a full fresh 8-sample window.
